// File: rtl/div_pkg.sv
// div_pkg: shared FSM states and sizing helpers for the BCD result converter.
package div_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  localparam int ADD3_THRESH = 5;
  function automatic int bcd_digits(input int n);
    return (n + 2) / 3;
  endfunction
endpackage

// File: rtl/bcd_dabble_step.sv
// bcd_dabble_step: one double-dabble iteration (add-3 correction, then shift in one bit).
module bcd_dabble_step import div_pkg::*; #(
  parameter int DIG = 2
) (
  input  logic [4*DIG-1:0] bcd,
  input  logic             bit_in,
  output logic [4*DIG-1:0] bcd_next
);
  logic [4*DIG-1:0] adj;
  always_comb begin
    adj = bcd;
    for (int k = 0; k < DIG; k++)
      adj[4*k+:4] = (bcd[4*k+:4] >= 4'(ADD3_THRESH)) ? bcd[4*k+:4] + 4'd3 : bcd[4*k+:4];
  end
  assign bcd_next = {adj[4*DIG-2:0], bit_in};
endmodule

// File: rtl/div_result_bcd.sv
// div_result_bcd: converts a divider quotient/remainder pair to packed BCD, one bit per clock.
module div_result_bcd import div_pkg::*; #(
  parameter  int N   = 4,
  localparam int DIG = bcd_digits(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_q,
  input  logic [N-1:0]     in_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4*DIG-1:0] out_q_bcd,
  output logic [4*DIG-1:0] out_r_bcd
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N-1:0]     q_sh_q, q_sh_d, r_sh_q, r_sh_d, q_rev;
  logic [4*DIG-1:0] q_acc_q, q_acc_d, r_acc_q, r_acc_d;
  logic [4*DIG-1:0] oq_q, oq_d, or_q, or_d, q_nx, r_nx;
  // The divider delivers Q with index 0 as MSB; flip it so both operands shift MSB-first.
  always_comb begin
    q_rev = '0;
    for (int i = 0; i < N; i++) q_rev[N-1-i] = in_q[i];
  end
  bcd_dabble_step #(.DIG(DIG)) u_q_step (.bcd(q_acc_q), .bit_in(q_sh_q[N-1]), .bcd_next(q_nx));
  bcd_dabble_step #(.DIG(DIG)) u_r_step (.bcd(r_acc_q), .bit_in(r_sh_q[N-1]), .bcd_next(r_nx));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_sh_d  = q_sh_q;
    r_sh_d  = r_sh_q;
    q_acc_d = q_acc_q;
    r_acc_d = r_acc_q;
    oq_d    = oq_q;
    or_d    = or_q;
    case (state_q)
      IDLE: if (in_valid) begin
        q_sh_d  = q_rev;
        r_sh_d  = in_r;
        q_acc_d = '0;
        r_acc_d = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        q_acc_d = q_nx;
        r_acc_d = r_nx;
        q_sh_d  = q_sh_q << 1;
        r_sh_d  = r_sh_q << 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N-1)) begin
          oq_d    = q_nx;
          or_d    = r_nx;
          state_d = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_sh_q  <= '0;
      r_sh_q  <= '0;
      q_acc_q <= '0;
      r_acc_q <= '0;
      oq_q    <= '0;
      or_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_sh_q  <= q_sh_d;
      r_sh_q  <= r_sh_d;
      q_acc_q <= q_acc_d;
      r_acc_q <= r_acc_d;
      oq_q    <= oq_d;
      or_q    <= or_d;
    end
  end
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_q_bcd = oq_q;
  assign out_r_bcd = or_q;
endmodule

// File: tb/tb_div_result_bcd.sv
// tb_div_result_bcd: table-driven and scoreboard checks of the BCD converter at N=4 and N=8.
module tb_div_result_bcd;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready, sel;
  logic [7:0] in_q, in_r;
  logic a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [7:0] a_oq, a_or;
  logic [11:0] b_oq, b_or;
  logic in_ready_s, out_valid_s;
  logic [11:0] oq_s, or_s;
  int checks = 0;
  int failures = 0;
  typedef struct {logic [11:0] q; logic [11:0] r;} exp_t;
  typedef struct {logic s; int q; int r; logic [11:0] eq; logic [11:0] er;} vec_t;
  exp_t sbq[$];
  vec_t tbl[8];
  always #5 clk = ~clk;
  div_result_bcd #(.N(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid && !sel), .in_ready(a_in_ready),
    .in_q(in_q[3:0]), .in_r(in_r[3:0]), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_q_bcd(a_oq), .out_r_bcd(a_or));
  div_result_bcd #(.N(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel), .in_ready(b_in_ready),
    .in_q(in_q), .in_r(in_r), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_q_bcd(b_oq), .out_r_bcd(b_or));
  assign in_ready_s  = sel ? b_in_ready : a_in_ready;
  assign out_valid_s = sel ? b_out_valid : a_out_valid;
  assign oq_s = sel ? b_oq : {4'b0, a_oq};
  assign or_s = sel ? b_or : {4'b0, a_or};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] rev(input int v, input int w);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < w; i++) x[i] = v[w-1-i];
    return x;
  endfunction

  task automatic drive(input logic s, input int q, input int r);
    sel  = s;
    in_q = rev(q, s ? 8 : 4);
    in_r = r[7:0];
  endtask

  task automatic push(input logic [11:0] q, input logic [11:0] r);
    exp_t e;
    e.q = q;
    e.r = r;
    sbq.push_back(e);
  endtask

  task automatic wait_accept();
    logic rdy;
    int n;
    rdy = 1'b0;
    n = 0;
    while (!rdy && n < 50) begin
      @(negedge clk) rdy = in_ready_s;
      @(posedge clk);
      n++;
    end
    if (!rdy) chk("accept_timeout", 0, 1);
    #1;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!out_valid_s && k < 40);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sbq.size() != 0) chk("drain_timeout", sbq.size(), 0);
    #1;
  endtask

  task automatic send(input logic s, input int q, input int r, input logic [11:0] eq, input logic [11:0] er);
    drive(s, q, r);
    in_valid = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    push(eq, er);
    wait_drain();
  endtask

  // Scoreboard: compare the head entry whenever a result is handed over.
  always @(negedge clk) begin
    if (!rst && out_valid_s && out_ready) begin
      if (sbq.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("q_bcd", int'(oq_s), int'(e.q));
        chk("r_bcd", int'(or_s), int'(e.r));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k, t, a1, a2;
    logic rdy;
    tbl[0] = '{1'b1, 255, 0,   12'h255, 12'h000};
    tbl[1] = '{1'b1, 0,   99,  12'h000, 12'h099};
    tbl[2] = '{1'b0, 0,   0,   12'h000, 12'h000};
    tbl[3] = '{1'b0, 10,  3,   12'h010, 12'h003};
    tbl[4] = '{1'b1, 128, 64,  12'h128, 12'h064};
    tbl[5] = '{1'b0, 7,   14,  12'h007, 12'h014};
    tbl[6] = '{1'b1, 1,   10,  12'h001, 12'h010};
    tbl[7] = '{1'b1, 37,  250, 12'h037, 12'h250};
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    sel = 1'b0;
    in_q = '0;
    in_r = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_in_ready", int'(in_ready_s), 1);
      chk("rst_out_valid", int'(out_valid_s), 0);
      chk("rst_q_bcd", int'(oq_s), 0);
      chk("rst_r_bcd", int'(or_s), 0);
    end
    // Latency: 13/2 at N=4, valid on the 4th edge after accept.
    drive(1'b0, 13, 2);
    in_valid = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    push(12'h013, 12'h002);
    wait_valid(k);
    chk("valid_latency", k, 4);
    chk("busy_in_ready", int'(in_ready_s), 0);
    @(posedge clk);
    #1;
    chk("post_hs_in_ready", int'(in_ready_s), 1);
    chk("post_hs_out_valid", int'(out_valid_s), 0);
    // Backpressure with the divide-by-zero pattern 15/5.
    out_ready = 1'b0;
    drive(1'b0, 15, 5);
    in_valid = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    push(12'h015, 12'h005);
    wait_valid(k);
    chk("bp_latency", k, 4);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_q = 8'($urandom_range(0, 15));
      in_r = 8'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      chk("bp_out_valid", int'(out_valid_s), 1);
      chk("bp_in_ready", int'(in_ready_s), 0);
      chk("bp_q_hold", int'(oq_s), 'h15);
      chk("bp_r_hold", int'(or_s), 'h05);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", int'(out_valid_s), 0);
    chk("bp_sb_empty", sbq.size(), 0);
    for (int i = 0; i < 8; i++) send(tbl[i].s, tbl[i].q, tbl[i].r, tbl[i].eq, tbl[i].er);
    // Reset on the 3rd SHIFT edge of an N=8 conversion discards it.
    drive(1'b1, 200, 50);
    in_valid = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_in_ready", int'(in_ready_s), 1);
    chk("midrst_out_valid", int'(out_valid_s), 0);
    chk("midrst_q_bcd", int'(oq_s), 0);
    chk("midrst_r_bcd", int'(or_s), 0);
    send(1'b1, 100, 7, 12'h100, 12'h007);
    // Back-to-back at N=4 with in_valid held high.
    drive(1'b0, 9, 1);
    push(12'h009, 12'h001);
    in_valid = 1'b1;
    t = 0;
    a1 = 0;
    a2 = 0;
    for (int c = 0; c < 40 && a2 == 0; c++) begin
      @(negedge clk) rdy = in_ready_s;
      @(posedge clk);
      t++;
      if (rdy) begin
        if (a1 == 0) begin
          a1 = t;
          #1 drive(1'b0, 15, 3);
          push(12'h015, 12'h003);
        end else begin
          a2 = t;
          #1 in_valid = 1'b0;
        end
      end
    end
    chk("b2b_spacing", a2 - a1, 6);
    wait_drain();
    chk("final_sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/div_result_bcd.md
Name: div_result_bcd

Overview:
- Sequential binary-to-BCD converter directly downstream of the combinational divider stage.
- Captures one quotient/remainder pair through a valid/ready handshake.
- Converts both values in parallel with the shift-and-add-3 (double-dabble) method, one bit per clock.
- Presents packed BCD digits to the display/readout logic under a valid/ready handshake.

Parameters:
- N, 4, operand width; must equal the divider's N. Legal range 2..32.
- DIG, (N+2)/3, localparam; BCD digits per result. Always ≥ ceil(N·log10 2).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  quotient/remainder pair present.
- in_ready  out  1  block can accept a pair.
- in_q  in  N  quotient. Index 0 is the MSB, matching the divider's Q ordering.
- in_r  in  N  remainder. Index N-1 is the MSB (conventional ordering).
- out_valid  out  1  BCD results valid.
- out_ready  in  1  consumer takes the results.
- out_q_bcd  out  4*DIG  quotient BCD. Digit k is bits [4k+3:4k]; digit 0 is the units digit.
- out_r_bcd  out  4*DIG  remainder BCD, same packing as out_q_bcd.

Behaviour:
- Reset:
  - Takes effect at the next clk edge with rst=1 and overrides everything else.
  - State=IDLE, in_ready=1, out_valid=0, out_q_bcd=0, out_r_bcd=0, bit counter=0, shift registers=0.
  - A reset during SHIFT or DONE aborts the conversion; the partial result is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1: bit-reverse in_q into an internal MSB-first register, capture in_r, clear both BCD accumulators, counter=0, go to SHIFT.
  - The output registers keep their last values but are not valid.
- SHIFT:
  - in_ready=0.
  - Each edge, for each operand independently:
    - Every BCD nibble ≥5 gets +3 (4-bit add, no carry between nibbles).
    - Then {bcd, operand} shifts left by 1; the operand MSB enters bcd bit 0.
  - The counter increments each edge. On the edge where counter==N-1, the final BCD values are written to out_q_bcd/out_r_bcd, out_valid=1, and the state goes to DONE.
- DONE:
  - out_valid=1, in_ready=0. Outputs stay stable until out_valid && out_ready.
  - On the handshake edge: out_valid=0, go to IDLE.
  - in_valid is ignored in DONE; there is no same-cycle pass-through.
- Timing:
  - out_valid rises exactly N edges after the accepting edge.
  - With out_ready held high, accept-to-accept spacing is N+2 edges.
- Width rules:
  - Unused upper digits are always 0.
  - A nibble never exceeds 9 after the final shift.
- Divide-by-zero from the upstream stage (Q all ones, R=D) is converted like any other value; no special case.
- in_q/in_r are sampled only on the accepting edge and may change freely afterwards.

Decomposition:
- Package div_pkg:
  - state enum {IDLE, SHIFT, DONE};
  - function bcd_digits(N) returning (N+2)/3;
  - constant ADD3_THRESH=5.
- Sub-module bcd_dabble_step (combinational, parameter DIG):
  - Inputs: bcd[4*DIG-1:0], bit_in.
  - Output: next bcd.
  - Instantiated twice, once for the quotient and once for the remainder.
- The counter, FSM and handshake stay in div_result_bcd.

Test Plan:
- N=4, reset then in_q=13 (index-0-MSB pattern 1101), in_r=2, out_ready=1 → out_valid at the 4th edge after accept; out_q_bcd=0x13, out_r_bcd=0x02; one cycle later in_ready=1.
- N=8, in_q=255, in_r=0 → out_q_bcd=0x255, out_r_bcd=0x000. Then in_q=0, in_r=99 → 0x000, 0x099.
- Backpressure: out_ready=0 for 10 cycles after out_valid → outputs unchanged and in_ready=0 throughout. in_valid pulses meanwhile are ignored. Raising out_ready → out_valid falls at the next edge.
- Reset mid-SHIFT (N=8, rst at 3rd SHIFT edge) → next cycle state IDLE, out_valid=0, outputs 0, in_ready=1. A new pair 100/7 then yields 0x100/0x007.
- Back-to-back with in_valid held high and out_ready=1 (N=4, pairs 9/1 then 15/3) → results 0x09/0x01, then 0x15/0x03. Accept-to-accept spacing is 6 edges.
- Divide-by-zero pattern (N=4, in_q=15, in_r=5) → out_q_bcd=0x15, out_r_bcd=0x05, no error indication.
